// File: rtl/f2sdram_safe_terminator_v2.sv
// f2sdram_safe_terminator_v2: parks one f2sdram Avalon-MM port cleanly on a core-reload request
// Ports: clk/rst_n (async active-low); term_req starts termination.
//   *_slave: user-facing Avalon-MM slave port. *_master: f2sdram-facing master port.
//   term_busy/term_done/timeout_flag/outstanding_reads: termination status.
module f2sdram_safe_terminator_v2 #(
  parameter int DATA_WIDTH = 64,
  parameter int BURSTCOUNT_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 29,
  parameter int OUTSTANDING_WIDTH = 10,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int BYTEENABLE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         term_req,
  input  logic                         waitrequest_master,
  output logic [BURSTCOUNT_WIDTH-1:0]  burstcount_master,
  output logic [ADDRESS_WIDTH-1:0]     address_master,
  input  logic [DATA_WIDTH-1:0]        readdata_master,
  input  logic                         readdatavalid_master,
  output logic                         read_master,
  output logic [DATA_WIDTH-1:0]        writedata_master,
  output logic [BYTEENABLE_WIDTH-1:0]  byteenable_master,
  output logic                         write_master,
  output logic                         waitrequest_slave,
  input  logic [BURSTCOUNT_WIDTH-1:0]  burstcount_slave,
  input  logic [ADDRESS_WIDTH-1:0]     address_slave,
  output logic [DATA_WIDTH-1:0]        readdata_slave,
  output logic                         readdatavalid_slave,
  input  logic                         read_slave,
  input  logic [DATA_WIDTH-1:0]        writedata_slave,
  input  logic [BYTEENABLE_WIDTH-1:0]  byteenable_slave,
  input  logic                         write_slave,
  output logic                         term_busy,
  output logic                         term_done,
  output logic                         timeout_flag,
  output logic [OUTSTANDING_WIDTH-1:0] outstanding_reads
);
  localparam int SW = (OUTSTANDING_WIDTH > BURSTCOUNT_WIDTH ? OUTSTANDING_WIDTH : BURSTCOUNT_WIDTH) + 1;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [2:0] {PASS, WR_FINISH, RD_HOLD, RD_DRAIN, SAFE} state_t;
  state_t state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BURSTCOUNT_WIDTH-1:0] bc_q, bc_d, acc_q, acc_d, rem_q, rem_d, acc_now, rem_now;
  logic wr_act_q, wr_act_d, flag_q, flag_d;
  logic [OUTSTANDING_WIDTH-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] sum_a, sum_b;
  logic pass, busy, rd_acc, wr_acc, wr_cont, tmo_hit;
  assign pass = state_q == PASS;
  assign busy = !pass && state_q != SAFE;
  assign read_master = pass ? read_slave : state_q == RD_HOLD;
  assign write_master = pass ? write_slave : state_q == WR_FINISH;
  assign address_master = pass ? address_slave : addr_q;
  assign burstcount_master = pass ? burstcount_slave : bc_q;
  assign writedata_master = pass ? writedata_slave : '0;
  assign byteenable_master = pass ? byteenable_slave : '0;
  assign waitrequest_slave = pass ? waitrequest_master : 1'b1;
  assign readdatavalid_slave = pass && readdatavalid_master;
  assign readdata_slave = readdata_master;
  assign term_busy = busy;
  assign term_done = state_q == SAFE;
  assign timeout_flag = flag_q;
  assign outstanding_reads = cnt_q;
  assign rd_acc = read_master && !waitrequest_master;
  assign wr_acc = write_slave && !waitrequest_master;
  // beats of the current write burst accepted so far, including this cycle
  assign acc_now = (wr_act_q ? acc_q : '0) + BURSTCOUNT_WIDTH'(wr_acc);
  assign rem_now = (wr_act_q ? bc_q : burstcount_slave) - acc_now;
  assign wr_cont = (wr_act_q || write_slave) && rem_now != '0;
  // wide sum so saturation and zero-clamping can be judged before truncation
  assign sum_a = SW'(cnt_q) + (rd_acc ? SW'(burstcount_master) : '0);
  assign sum_b = sum_a - SW'(readdatavalid_master && sum_a != '0);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && busy && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    bc_d = bc_q;
    acc_d = acc_q;
    rem_d = rem_q;
    wr_act_d = wr_act_q;
    flag_d = flag_q;
    cnt_d = |sum_b[SW-1:OUTSTANDING_WIDTH] ? '1 : sum_b[OUTSTANDING_WIDTH-1:0];
    case (state_q)
      PASS: begin
        if (write_slave && !wr_act_q) begin
          addr_d = address_slave;
          bc_d = burstcount_slave;
        end
        acc_d = acc_now;
        rem_d = rem_now;
        wr_act_d = wr_cont && !term_req;
        if (term_req) begin
          if (wr_cont) state_d = WR_FINISH;
          else if (read_slave && waitrequest_master) begin
            state_d = RD_HOLD;
            addr_d = address_slave;
            bc_d = burstcount_slave;
          end else state_d = RD_DRAIN;
        end
      end
      WR_FINISH: begin
        rem_d = waitrequest_master ? rem_q : rem_q - BURSTCOUNT_WIDTH'(1);
        state_d = (!waitrequest_master && rem_q == BURSTCOUNT_WIDTH'(1)) ? RD_DRAIN : WR_FINISH;
      end
      RD_HOLD: state_d = waitrequest_master ? RD_HOLD : RD_DRAIN;
      RD_DRAIN: state_d = cnt_d == '0 ? SAFE : RD_DRAIN;
      SAFE: state_d = term_req ? SAFE : PASS;
      default: state_d = PASS;
    endcase
    if (tmo_hit) begin
      state_d = SAFE;
      flag_d = 1'b1;
      cnt_d = '0;
    end
    tmo_d = (busy && state_d != PASS && state_d != SAFE) ? tmo_q + TW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PASS;
      addr_q <= '0;
      bc_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      wr_act_q <= 1'b0;
      flag_q <= 1'b0;
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      bc_q <= bc_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      wr_act_q <= wr_act_d;
      flag_q <= flag_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
endmodule

// File: tb/tb_f2sdram_safe_terminator_v2.sv
// tb_f2sdram_safe_terminator_v2: directed self-checking bench for the f2sdram terminator
module tb_f2sdram_safe_terminator_v2;
  logic clk = 1'b0;
  logic rst_n, term_req, waitrequest_master, readdatavalid_master, read_slave, write_slave;
  logic [7:0] burstcount_master, burstcount_slave, byteenable_master, byteenable_slave;
  logic [28:0] address_master, address_slave;
  logic [63:0] readdata_master, writedata_master, readdata_slave, writedata_slave;
  logic read_master, write_master, waitrequest_slave, readdatavalid_slave;
  logic term_busy, term_done, timeout_flag;
  logic [9:0] outstanding_reads;
  int checks = 0;
  int errors = 0;
  f2sdram_safe_terminator_v2 #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .term_req(term_req),
    .waitrequest_master(waitrequest_master), .burstcount_master(burstcount_master),
    .address_master(address_master), .readdata_master(readdata_master),
    .readdatavalid_master(readdatavalid_master), .read_master(read_master),
    .writedata_master(writedata_master), .byteenable_master(byteenable_master),
    .write_master(write_master), .waitrequest_slave(waitrequest_slave),
    .burstcount_slave(burstcount_slave), .address_slave(address_slave),
    .readdata_slave(readdata_slave), .readdatavalid_slave(readdatavalid_slave),
    .read_slave(read_slave), .writedata_slave(writedata_slave),
    .byteenable_slave(byteenable_slave), .write_slave(write_slave),
    .term_busy(term_busy), .term_done(term_done), .timeout_flag(timeout_flag),
    .outstanding_reads(outstanding_reads)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    waitrequest_master = 1'b0;
    readdatavalid_master = 1'b0;
    readdata_master = '0;
    read_slave = 1'b0;
    write_slave = 1'b0;
    burstcount_slave = '0;
    address_slave = '0;
    writedata_slave = '0;
    byteenable_slave = '0;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    term_req = 1'b0;
    idle();
    read_slave = 1'b1;
    address_slave = 29'h0ABCDE;
    burstcount_slave = 8'd7;
    waitrequest_master = 1'b1;
    #2;
    chk("rst_busy", term_busy, 0);
    chk("rst_done", term_done, 0);
    chk("rst_flag", timeout_flag, 0);
    chk("rst_cnt", outstanding_reads, 0);
    chk("rst_pass_rm", read_master, 1);
    chk("rst_pass_addr", address_master, 29'h0ABCDE);
    chk("rst_pass_bc", burstcount_master, 7);
    chk("rst_pass_wreq", waitrequest_slave, 1);
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    // write burst of 8: three beats accepted, then termination during a stall
    write_slave = 1'b1;
    address_slave = 29'h100;
    burstcount_slave = 8'd8;
    byteenable_slave = 8'hFF;
    writedata_slave = 64'h1111_2222_3333_4444;
    #1;
    chk("wr_pass_wm", write_master, 1);
    chk("wr_pass_be", byteenable_master, 8'hFF);
    chk("wr_pass_wd", writedata_master, 64'h1111_2222_3333_4444);
    chk("wr_pass_wreq", waitrequest_slave, 0);
    tick();
    tick();
    tick();
    waitrequest_master = 1'b1;
    term_req = 1'b1;
    #1;
    chk("wr_term_wreq", waitrequest_slave, 1);
    tick();
    write_slave = 1'b0;
    address_slave = 29'h999;
    burstcount_slave = 8'd1;
    for (int i = 0; i < 6; i++) begin
      waitrequest_master = (i == 2);
      if (i == 3) term_req = 1'b0;
      #1;
      chk("wf_wm", write_master, 1);
      chk("wf_be", byteenable_master, 0);
      chk("wf_wd", writedata_master, 0);
      chk("wf_addr", address_master, 29'h100);
      chk("wf_bc", burstcount_master, 8);
      chk("wf_wreq", waitrequest_slave, 1);
      chk("wf_busy", term_busy, 1);
      tick();
    end
    waitrequest_master = 1'b0;
    #1;
    chk("wf_end_wm", write_master, 0);
    chk("wf_end_busy", term_busy, 1);
    chk("wf_end_wreq", waitrequest_slave, 1);
    tick();
    chk("wf_done", term_done, 1);
    chk("wf_done_busy", term_busy, 0);
    tick();
    chk("wf_back_done", term_done, 0);
    chk("wf_back_wreq", waitrequest_slave, 0);
    // read burst of 16: four beats returned, then drain on termination
    read_slave = 1'b1;
    address_slave = 29'h200;
    burstcount_slave = 8'd16;
    #1;
    chk("rd_pass_rm", read_master, 1);
    chk("rd_pass_addr", address_master, 29'h200);
    tick();
    read_slave = 1'b0;
    #1;
    chk("rd_cnt16", outstanding_reads, 16);
    for (int i = 0; i < 4; i++) begin
      readdatavalid_master = 1'b1;
      readdata_master = 64'hA0 + 64'(i);
      #1;
      chk("rd_pass_rdv", readdatavalid_slave, 1);
      chk("rd_pass_rdata", readdata_slave, 64'hA0 + 64'(i));
      tick();
    end
    readdatavalid_master = 1'b0;
    #1;
    chk("rd_cnt12", outstanding_reads, 12);
    term_req = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      readdatavalid_master = (i != 5);
      readdata_master = 64'hB0 + 64'(i);
      #1;
      chk("dr_rdv", readdatavalid_slave, 0);
      chk("dr_rdata", readdata_slave, 64'hB0 + 64'(i));
      chk("dr_rm", read_master, 0);
      chk("dr_wm", write_master, 0);
      chk("dr_wreq", waitrequest_slave, 1);
      chk("dr_done", term_done, 0);
      tick();
    end
    readdatavalid_master = 1'b0;
    #1;
    chk("dr_done_hi", term_done, 1);
    chk("dr_cnt0", outstanding_reads, 0);
    term_req = 1'b0;
    tick();
    chk("dr_back", term_done, 0);
    // accepted command and returned beat in the same cycle
    read_slave = 1'b1;
    address_slave = 29'h10;
    burstcount_slave = 8'd2;
    tick();
    burstcount_slave = 8'd4;
    readdatavalid_master = 1'b1;
    #1;
    chk("sim_cnt2", outstanding_reads, 2);
    tick();
    read_slave = 1'b0;
    readdatavalid_master = 1'b0;
    #1;
    chk("sim_cnt5", outstanding_reads, 5);
    // read stalled when termination arrives
    read_slave = 1'b1;
    address_slave = 29'h300;
    burstcount_slave = 8'd4;
    waitrequest_master = 1'b1;
    term_req = 1'b1;
    #1;
    chk("rh_pass_rm", read_master, 1);
    tick();
    read_slave = 1'b0;
    address_slave = 29'h3FF;
    burstcount_slave = 8'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rh_rm", read_master, 1);
      chk("rh_addr", address_master, 29'h300);
      chk("rh_bc", burstcount_master, 4);
      chk("rh_wreq", waitrequest_slave, 1);
      chk("rh_busy", term_busy, 1);
      tick();
    end
    waitrequest_master = 1'b0;
    #1;
    chk("rh_acc_rm", read_master, 1);
    tick();
    chk("rh_cnt9", outstanding_reads, 9);
    chk("rh_drain_rm", read_master, 0);
    for (int i = 0; i < 9; i++) begin
      readdatavalid_master = 1'b1;
      #1;
      chk("rh_done_lo", term_done, 0);
      chk("rh_rdv", readdatavalid_slave, 0);
      tick();
    end
    readdatavalid_master = 1'b0;
    #1;
    chk("rh_done_hi", term_done, 1);
    term_req = 1'b0;
    tick();
    // drain that never completes: timeout after 100 busy cycles
    read_slave = 1'b1;
    address_slave = 29'h500;
    burstcount_slave = 8'd3;
    tick();
    read_slave = 1'b0;
    #1;
    chk("to_cnt3", outstanding_reads, 3);
    term_req = 1'b1;
    tick();
    for (int i = 0; i < 99; i++) tick();
    chk("to_busy99", term_busy, 1);
    chk("to_done99", term_done, 0);
    chk("to_flag99", timeout_flag, 0);
    tick();
    chk("to_done", term_done, 1);
    chk("to_flag", timeout_flag, 1);
    chk("to_cnt0", outstanding_reads, 0);
    term_req = 1'b0;
    tick();
    chk("to_flag_pass", timeout_flag, 1);
    chk("to_busy_pass", term_busy, 0);
    term_req = 1'b1;
    tick();
    tick();
    chk("to_done2", term_done, 1);
    chk("to_flag2", timeout_flag, 1);
    term_req = 1'b0;
    tick();
    // reset in the middle of write completion
    write_slave = 1'b1;
    address_slave = 29'h400;
    burstcount_slave = 8'd4;
    byteenable_slave = 8'hFF;
    waitrequest_master = 1'b1;
    term_req = 1'b1;
    tick();
    chk("mr_wm", write_master, 1);
    chk("mr_be", byteenable_master, 0);
    chk("mr_busy", term_busy, 1);
    byteenable_slave = 8'h0F;
    address_slave = 29'h455;
    rst_n = 1'b0;
    #1;
    chk("mr_pass_wm", write_master, 1);
    chk("mr_pass_be", byteenable_master, 8'h0F);
    chk("mr_pass_addr", address_master, 29'h455);
    chk("mr_busy0", term_busy, 0);
    chk("mr_flag0", timeout_flag, 0);
    chk("mr_cnt0", outstanding_reads, 0);
    write_slave = 1'b0;
    waitrequest_master = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rr_busy", term_busy, 1);
    chk("rr_wm", write_master, 0);
    chk("rr_rm", read_master, 0);
    tick();
    chk("rr_done", term_done, 1);
    term_req = 1'b0;
    tick();
    chk("rr_back_done", term_done, 0);
    chk("rr_back_busy", term_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
